// File: rtl/dcache_ctrl_pkg.sv
// Shared constants, FSM encoding and word-select helpers for the direct-mapped data cache.
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 128
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package dcache_ctrl_pkg;
  localparam int LINE_W = `BLOCK_SIZE;
  localparam int ADDR_W = `WORD_SIZE;
  localparam int WORDS  = LINE_W / 32;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int WSEL_W = $clog2(WORDS);

  typedef enum logic [3:0] {
    IDLE, LOOKUP, WB, FILL, REFILL, RESP, FL_SCAN, FL_WB, DONE
  } state_t;

  // Word 0 lives in the MSBs of a line.
  function automatic logic [31:0] word_get(input logic [LINE_W-1:0] line,
                                           input logic [WSEL_W-1:0] k);
    int b;
    b = LINE_W - 32 - 32 * int'(k);
    return line[b +: 32];
  endfunction

  function automatic logic [LINE_W-1:0] word_put(input logic [LINE_W-1:0] line,
                                                 input logic [WSEL_W-1:0] k,
                                                 input logic [31:0] w);
    logic [LINE_W-1:0] r;
    int b;
    r = line;
    b = LINE_W - 32 - 32 * int'(k);
    r[b +: 32] = w;
    return r;
  endfunction
endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side and datamem-side bus of the data cache; master = cache, slave = CPU/datamem side.
interface dcache_ctrl_if import dcache_ctrl_pkg::*; #(
  parameter int ADDR_BITS = ADDR_W,
  parameter int LINE_BITS = LINE_W
) ();
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_BITS-1:0] cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [31:0]          cpu_rdata;
  logic                 cpu_ready;
  logic                 halt;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_read;
  logic                 mem_write;
  logic [LINE_BITS-1:0] mem_wdata;
  logic [LINE_BITS-1:0] mem_rdata1;
  logic [LINE_BITS-1:0] mem_rdata2;
  logic                 mem_flush;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, halt, mem_rdata1, mem_rdata2,
    output cpu_rdata, cpu_ready, mem_addr, mem_read, mem_write, mem_wdata, mem_flush
  );
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, halt, mem_rdata1, mem_rdata2,
    input  cpu_rdata, cpu_ready, mem_addr, mem_read, mem_write, mem_wdata, mem_flush
  );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one write port, combinational read, async-cleared valid/dirty.
module dcache_array #(
  parameter int NUM_LINES = 16,
  parameter int IDX_BITS  = 4,
  parameter int TAG_BITS  = 24,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [IDX_BITS-1:0]  widx,
  input  logic [TAG_BITS-1:0]  wtag,
  input  logic [LINE_BITS-1:0] wdata,
  input  logic                 wvalid,
  input  logic                 wdirty,
  input  logic [IDX_BITS-1:0]  ridx,
  output logic [TAG_BITS-1:0]  rtag,
  output logic [LINE_BITS-1:0] rdata,
  output logic                 rvalid,
  output logic                 rdirty
);
  logic [NUM_LINES-1:0][TAG_BITS-1:0]  tags;
  logic [NUM_LINES-1:0][LINE_BITS-1:0] data;
  logic [NUM_LINES-1:0]                valid, dirty;

  always_ff @(posedge clk)
    if (we) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (we) begin
      valid[widx] <= wvalid;
      dirty[widx] <= wdirty;
    end

  assign rtag   = tags[ridx];
  assign rdata  = data[ridx];
  assign rvalid = valid[ridx];
  assign rdirty = dirty[ridx];
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller with halt-time flush.
// Define DCACHE_PREFETCH_EN to also install the next sequential block (mem_rdata2) on a miss.
module dcache_ctrl import dcache_ctrl_pkg::*; #(
  parameter int NUM_LINES = 16,
  parameter int LINE_BITS = LINE_W,
  parameter int ADDR_BITS = ADDR_W
) (
  input logic clk,
  input logic rst_n,
  dcache_ctrl_if.master bus
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_BITS - IDX_W - OFF_W;

  state_t state, nxt;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 we_q;
  logic [31:0]          wdata_q;
  logic [IDX_W-1:0]     scan_idx;

  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WSEL_W-1:0] wsel_q;
  assign tag_q  = addr_q[ADDR_BITS-1 -: TAG_W];
  assign idx_q  = addr_q[OFF_W +: IDX_W];
  assign wsel_q = addr_q[OFF_W-1:2];

  logic                 a_we, a_wvalid, a_wdirty, r_valid, r_dirty;
  logic [IDX_W-1:0]     a_widx, a_ridx;
  logic [TAG_W-1:0]     a_wtag, r_tag;
  logic [LINE_BITS-1:0] a_wdata, r_data;

  dcache_array #(.NUM_LINES(NUM_LINES), .IDX_BITS(IDX_W), .TAG_BITS(TAG_W), .LINE_BITS(LINE_BITS)) u_array (
    .clk(clk), .rst_n(rst_n),
    .we(a_we), .widx(a_widx), .wtag(a_wtag), .wdata(a_wdata), .wvalid(a_wvalid), .wdirty(a_wdirty),
    .ridx(a_ridx), .rtag(r_tag), .rdata(r_data), .rvalid(r_valid), .rdirty(r_dirty)
  );

  logic hit, last;
  assign hit  = r_valid && (r_tag == tag_q);
  assign last = (scan_idx == IDX_W'(NUM_LINES - 1));

`ifdef DCACHE_PREFETCH_EN
  // The array has one write port, so the prefetched block is parked here and
  // installed during the IDLE cycle that always follows RESP.
  logic                   pf_pend;
  logic [IDX_W-1:0]       pf_idx;
  logic [TAG_W-1:0]       pf_tag;
  logic [LINE_BITS-1:0]   pf_data;
  logic [TAG_W+IDX_W-1:0] nxt_blk;
  assign nxt_blk = {tag_q, idx_q} + (TAG_W+IDX_W)'(1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pf_pend <= 1'b0;
      pf_idx  <= '0;
      pf_tag  <= '0;
      pf_data <= '0;
    end else if (state == REFILL) begin
      pf_pend <= 1'b1;
      pf_idx  <= nxt_blk[IDX_W-1:0];
      pf_tag  <= nxt_blk[TAG_W+IDX_W-1:IDX_W];
      pf_data <= bus.mem_rdata2;
    end else if (state == IDLE) begin
      pf_pend <= 1'b0;
    end
`else
  logic unused_rdata2;
  assign unused_rdata2 = ^bus.mem_rdata2;
`endif
  logic unused_lsb;
  assign unused_lsb = ^addr_q[1:0];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      scan_idx <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && !bus.halt && bus.cpu_req) begin
        addr_q  <= bus.cpu_addr;
        we_q    <= bus.cpu_we;
        wdata_q <= bus.cpu_wdata;
      end
      if ((state == FL_SCAN && !(r_valid && r_dirty)) || state == FL_WB)
        scan_idx <= scan_idx + IDX_W'(1);
    end

  logic                 cpu_ready, mem_read, mem_write, mem_flush;
  logic [31:0]          cpu_rdata;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [LINE_BITS-1:0] mem_wdata;

  always_comb begin
    nxt       = state;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_flush = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    a_we      = 1'b0;
    a_widx    = idx_q;
    a_wtag    = r_tag;
    a_wdata   = r_data;
    a_wvalid  = r_valid;
    a_wdirty  = 1'b0;
    a_ridx    = idx_q;
    case (state)
      IDLE: begin
`ifdef DCACHE_PREFETCH_EN
        if (pf_pend) begin
          a_ridx = pf_idx;
          if (!(r_valid && r_dirty)) begin
            a_we     = 1'b1;
            a_widx   = pf_idx;
            a_wtag   = pf_tag;
            a_wdata  = pf_data;
            a_wvalid = 1'b1;
          end
        end
`endif
        if (bus.halt)         nxt = FL_SCAN;
        else if (bus.cpu_req) nxt = LOOKUP;
      end
      LOOKUP: nxt = hit ? RESP : (r_valid && r_dirty) ? WB : FILL;
      WB: begin
        mem_write = 1'b1;
        mem_addr  = {r_tag, idx_q, {OFF_W{1'b0}}};
        mem_wdata = r_data;
        a_we      = 1'b1;
        nxt       = FILL;
      end
      FILL: begin
        mem_read = 1'b1;
        mem_addr = {tag_q, idx_q, {OFF_W{1'b0}}};
        nxt      = REFILL;
      end
      REFILL: begin
        a_we     = 1'b1;
        a_wtag   = tag_q;
        a_wdata  = bus.mem_rdata1;
        a_wvalid = 1'b1;
        nxt      = RESP;
      end
      RESP: begin
        cpu_ready = 1'b1;
        if (we_q) begin
          a_we     = 1'b1;
          a_wdata  = word_put(r_data, wsel_q, wdata_q);
          a_wdirty = 1'b1;
        end else begin
          cpu_rdata = word_get(r_data, wsel_q);
        end
        nxt = IDLE;
      end
      FL_SCAN: begin
        a_ridx = scan_idx;
        if (r_valid && r_dirty) nxt = FL_WB;
        else if (last)          nxt = DONE;
      end
      FL_WB: begin
        a_ridx    = scan_idx;
        a_widx    = scan_idx;
        a_we      = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {r_tag, scan_idx, {OFF_W{1'b0}}};
        mem_wdata = r_data;
        nxt       = last ? DONE : FL_SCAN;
      end
      DONE:    mem_flush = 1'b1;
      default: nxt = IDLE;
    endcase
  end

  assign bus.cpu_ready = cpu_ready;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.mem_flush = mem_flush;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed steps plus random traffic against a flat-memory reference.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_ctrl_if bus ();
  dcache_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  // datamem stand-in: 64 blocks of 128 bits, registered read of two blocks
  logic [127:0] mem [64];
  always @(posedge clk) begin
    if (bus.mem_read) begin
      bus.mem_rdata1 <= mem[bus.mem_addr[9:4]];
      bus.mem_rdata2 <= mem[bus.mem_addr[9:4] + 6'd1];
    end
    if (bus.mem_write) mem[bus.mem_addr[9:4]] <= bus.mem_wdata;
  end

  // strobe monitor
  int rd_q[$];
  int wb_q[$];
  logic [127:0] wbd_q[$];
  int both_cnt = 0;
  always @(negedge clk) begin
    if (bus.mem_read) rd_q.push_back(int'(bus.mem_addr));
    if (bus.mem_write) begin
      wb_q.push_back(int'(bus.mem_addr));
      wbd_q.push_back(bus.mem_wdata);
    end
    if (bus.mem_read && bus.mem_write) both_cnt++;
  end

  // reference: architectural word memory + which blocks a direct-mapped cache holds
  logic [31:0] ref_w [256];
  bit m_v [16];
  bit m_d [16];
  int m_t [16];

  function automatic logic [127:0] line_of(input int b);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[127-32*k -: 32] = ref_w[b*4+k];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, " outs"}, {bus.cpu_ready, bus.mem_read, bus.mem_write, bus.mem_flush,
                        bus.mem_addr, bus.cpu_rdata}, '0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_v[i] = 0; m_d[i] = 0; m_t[i] = 0; end
    for (int i = 0; i < 256; i++) ref_w[i] = mem[i/4][127-32*(i%4) -: 32];
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0; bus.cpu_req = 1'b0; bus.halt = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_quiet(nm);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic access(input bit we, input int a, input logic [31:0] d,
                        input int halt_at, input string nm);
    int idx, tg, n, old_a, nb, ni;
    bit hit, dm;
    logic [127:0] old_line;
    logic [31:0] exp_rd, got;
    idx = (a >> 4) & 15;
    tg = a >> 8;
    hit = m_v[idx] && m_t[idx] == tg;
    dm = !hit && m_v[idx] && m_d[idx];
    old_a = (m_t[idx] * 16 + idx) * 16;
    old_line = line_of(old_a >> 4);
    exp_rd = ref_w[a >> 2];
    @(negedge clk);
    rd_q.delete(); wb_q.delete(); wbd_q.delete();
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == halt_at) bus.halt = 1'b1;
    end while (!bus.cpu_ready && n < 20);
    got = bus.cpu_rdata;
    bus.cpu_req = 1'b0;
    chk({nm, " latency"}, n, hit ? 2 : dm ? 5 : 4);
    if (!we) chk({nm, " rdata"}, got, exp_rd);
    chk({nm, " reads"}, rd_q.size(), hit ? 0 : 1);
    if (!hit && rd_q.size() == 1) chk({nm, " rd addr"}, rd_q[0], a & ~15);
    chk({nm, " writes"}, wb_q.size(), dm ? 1 : 0);
    if (dm && wb_q.size() == 1) begin
      chk({nm, " wb addr"}, wb_q[0], old_a);
      chk({nm, " wb data"}, wbd_q[0], old_line);
    end
    if (!hit) begin
      m_v[idx] = 1; m_t[idx] = tg; m_d[idx] = 0;
`ifdef DCACHE_PREFETCH_EN
      nb = (a >> 4) + 1; ni = nb & 15;
      if (!(m_v[ni] && m_d[ni])) begin m_v[ni] = 1; m_t[ni] = nb >> 4; m_d[ni] = 0; end
`else
      nb = 0; ni = 0;
`endif
    end
    if (we) begin m_d[idx] = 1; ref_w[a >> 2] = d; end
  endtask

  task automatic flush(input string nm);
    int exp_q[$];
    int n, bad;
    bit hold, rdy;
    for (int i = 0; i < 16; i++) if (m_v[i] && m_d[i]) exp_q.push_back((m_t[i] * 16 + i) * 16);
    wb_q.delete();
    bus.halt = 1'b1;
    n = 0;
    while (!bus.mem_flush && n < 200) begin @(negedge clk); n++; end
    chk({nm, " flush reached"}, bus.mem_flush, 1);
    chk({nm, " wb count"}, wb_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wb_q.size(); i++) chk({nm, " wb order"}, wb_q[i], exp_q[i]);
    bad = 0;
    for (int b = 0; b < 64; b++) if (mem[b] !== line_of(b)) bad++;
    chk({nm, " mem image"}, bad, 0);
    bus.halt = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
    hold = 1; rdy = 0;
    repeat (6) begin @(negedge clk); hold &= bus.mem_flush; rdy |= bus.cpu_ready; end
    bus.cpu_req = 1'b0;
    chk({nm, " flush sticky"}, hold, 1);
    chk({nm, " no cpu in DONE"}, rdy, 0);
  endtask

  initial begin
    int n;
    bit saw;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.halt = 0;
    bus.mem_rdata1 = 0; bus.mem_rdata2 = 0;
    for (int i = 0; i < 256; i++) ref_w[i] = $urandom;
    ref_w[32'h40 >> 2] = 32'hDEADBEEF;
    for (int b = 0; b < 64; b++) mem[b] = line_of(b);

    do_reset("reset");
    access(0, 32'h40, 0, 0, "load 0x40 miss");
    access(0, 32'h40, 0, 0, "load 0x40 hit");
    access(1, 32'h40, 32'h12345678, 0, "store 0x40");
    access(0, 32'h140, 0, 0, "conflict load");
    access(0, 32'h40, 0, 0, "reload 0x40");
    // next-block pattern: idx 5 miss, idx 6 follow-up, idx 6 dirty then idx 5 re-miss
    access(0, 32'h50, 0, 0, "load idx5");
    access(0, 32'h64, 0, 0, "load idx6");
    access(1, 32'h60, $urandom, 0, "store idx6");
    access(0, 32'h150, 0, 0, "reload idx5");
    access(0, 32'h60, 0, 0, "load idx6 again");

    for (int i = 0; i < 150; i++)
      access($urandom_range(0, 1), $urandom_range(0, 255) * 4, $urandom, 0, "random");
    flush("flush1");

    do_reset("reset2");
    chk("flush cleared", bus.mem_flush, 0);
    access(0, 32'h40, 0, 0, "pre load");
    access(1, 32'h44, 32'hCAFEF00D, 0, "pre store");
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h200;
    n = 0; saw = 0;
    while (!saw && n < 10) begin @(negedge clk); n++; saw = bus.mem_read; end
    chk("fill reached", saw, 1);
    rst_n = 1'b0; bus.cpu_req = 1'b0;
    #1 chk_quiet("reset in FILL");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    access(0, 32'h40, 0, 0, "post-reset load");
    access(0, 32'h44, 0, 0, "store lost");

    do_reset("reset3");
    access(1, 32'h000, $urandom, 0, "dirty idx0");
    access(1, 32'h030, $urandom, 0, "dirty idx3");
    access(0, 32'h150, 0, 0, "clean idx5");
    access(0, 32'h280, 0, 1, "halt in flight");
    flush("flush2");
    chk("wb pulses", wb_q.size(), 2);
    chk("no dual strobe", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
